// File: rtl/blowfish_feistel_core_if.sv
// Bus bundle between the bcrypt controller and the Feistel core: request/result handshake plus
// two synchronous SRAM read ports. FEISTEL_CHAIN_EN adds the chain request bit.
interface blowfish_feistel_core_if #(
  parameter int ADDR_W = 12
);
  logic              start;
  logic              decrypt;
  logic [31:0]       l_in;
  logic [31:0]       r_in;
`ifdef FEISTEL_CHAIN_EN
  logic              chain;
`endif
  logic              ready;
  logic              done;
  logic [31:0]       result_l;
  logic [31:0]       result_r;
  logic [31:0]       data_out_a;
  logic [31:0]       data_out_b;
  logic [ADDR_W-1:0] addr_a;
  logic [ADDR_W-1:0] addr_b;
  logic              cs_a_l, we_a_l, oe_a_l;
  logic              cs_b_l, we_b_l, oe_b_l;

  modport slave (
`ifdef FEISTEL_CHAIN_EN
    input  chain,
`endif
    input  start, decrypt, l_in, r_in, data_out_a, data_out_b,
    output ready, done, result_l, result_r,
    output addr_a, cs_a_l, we_a_l, oe_a_l,
    output addr_b, cs_b_l, we_b_l, oe_b_l
  );

  modport master (
`ifdef FEISTEL_CHAIN_EN
    output chain,
`endif
    output start, decrypt, l_in, r_in, data_out_a, data_out_b,
    input  ready, done, result_l, result_r,
    input  addr_a, cs_a_l, we_a_l, oe_a_l,
    input  addr_b, cs_b_l, we_b_l, oe_b_l
  );
endinterface

// File: rtl/blowfish_feistel_core.sv
// Blowfish Feistel engine: one 64-bit block per request, S-boxes and P-array read from a dual-read SRAM.
// Optional macro FEISTEL_CHAIN_EN: chain=1 reloads L/R from the previous result instead of l_in/r_in.
module blowfish_feistel_core #(
  parameter int ROUNDS = 16,
  parameter int ADDR_W = 12,
  parameter int S_BASE = 0,
  parameter int P_BASE = 1024
) (
  input  logic                    clk,
  input  logic                    reset_l,
  blowfish_feistel_core_if.slave  bus
);

  localparam int CNT_W = $clog2(ROUNDS + 2);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_RX   = 3'd1;
  localparam logic [2:0] S_F1   = 3'd2;
  localparam logic [2:0] S_F2   = 3'd3;
  localparam logic [2:0] S_FIN  = 3'd4;
  localparam logic [2:0] S_DONE = 3'd5;

  localparam logic [ADDR_W-1:0] A_S0 = ADDR_W'(S_BASE);
  localparam logic [ADDR_W-1:0] A_S1 = ADDR_W'(S_BASE + 256);
  localparam logic [ADDR_W-1:0] A_S2 = ADDR_W'(S_BASE + 512);
  localparam logic [ADDR_W-1:0] A_S3 = ADDR_W'(S_BASE + 768);
  localparam logic [ADDR_W-1:0] A_P  = ADDR_W'(P_BASE);
  localparam logic [CNT_W-1:0]  LAST_I = CNT_W'(ROUNDS - 1);

  // Decrypt walks the P-array backwards: round i uses P[ROUNDS+1-i].
  function automatic logic [CNT_W-1:0] p_idx(input logic dec, input logic [CNT_W-1:0] i);
    return dec ? (CNT_W'(ROUNDS + 1) - i) : i;
  endfunction

  function automatic logic [ADDR_W-1:0] a_p(input logic [CNT_W-1:0] idx);
    return A_P + ADDR_W'(idx);
  endfunction

  function automatic logic [ADDR_W-1:0] a_s(input logic [ADDR_W-1:0] base, input logic [7:0] b);
    return base + ADDR_W'(b);
  endfunction

  logic [2:0]        r_state;
  logic [CNT_W-1:0]  r_i;
  logic              r_dec;
  logic [31:0]       r_l, r_r, r_f;
  logic [31:0]       r_res_l, r_res_r;
  logic              r_done;

  logic              w_accept;
  logic [31:0]       w_lx, w_fo;
  logic [31:0]       w_load_l, w_load_r;
  logic [CNT_W-1:0]  w_fl, w_fr;
  logic [ADDR_W-1:0] w_addr_a, w_addr_b;
  logic              w_cs_a_l, w_cs_b_l;

  assign w_accept = (r_state == S_IDLE) && bus.start && reset_l;
  assign w_lx     = r_l ^ bus.data_out_a;
  assign w_fo     = (r_f ^ bus.data_out_a) + bus.data_out_b;
  assign w_fl     = r_dec ? '0 : CNT_W'(ROUNDS + 1);
  assign w_fr     = r_dec ? CNT_W'(1) : CNT_W'(ROUNDS);

`ifdef FEISTEL_CHAIN_EN
  assign w_load_l = bus.chain ? r_res_l : bus.l_in;
  assign w_load_r = bus.chain ? r_res_r : bus.r_in;
`else
  assign w_load_l = bus.l_in;
  assign w_load_r = bus.r_in;
`endif

  // Read addresses are issued combinationally so data lands in the following state.
  always_comb begin
    w_addr_a = '0;
    w_addr_b = '0;
    w_cs_a_l = 1'b1;
    w_cs_b_l = 1'b1;
    case (r_state)
      S_IDLE: if (w_accept) begin
        w_addr_a = a_p(p_idx(bus.decrypt, '0));
        w_cs_a_l = 1'b0;
      end
      S_RX: begin
        w_addr_a = a_s(A_S0, w_lx[31:24]);
        w_addr_b = a_s(A_S1, w_lx[23:16]);
        w_cs_a_l = 1'b0;
        w_cs_b_l = 1'b0;
      end
      S_F1: begin
        w_addr_a = a_s(A_S2, r_l[15:8]);
        w_addr_b = a_s(A_S3, r_l[7:0]);
        w_cs_a_l = 1'b0;
        w_cs_b_l = 1'b0;
      end
      S_F2: begin
        if (r_i != LAST_I) begin
          w_addr_a = a_p(p_idx(r_dec, r_i + 1'b1));
          w_cs_a_l = 1'b0;
        end else begin
          w_addr_a = a_p(w_fl);
          w_addr_b = a_p(w_fr);
          w_cs_a_l = 1'b0;
          w_cs_b_l = 1'b0;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      r_state <= S_IDLE;
      r_i     <= '0;
      r_dec   <= 1'b0;
      r_res_l <= '0;
      r_res_r <= '0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: if (w_accept) begin
          r_state <= S_RX;
          r_i     <= '0;
          r_dec   <= bus.decrypt;
        end
        S_RX: r_state <= S_F1;
        S_F1: r_state <= S_F2;
        S_F2: begin
          if (r_i != LAST_I) begin
            r_i     <= r_i + 1'b1;
            r_state <= S_RX;
          end else begin
            r_state <= S_FIN;
          end
        end
        S_FIN: begin
          r_res_l <= r_r ^ bus.data_out_a;
          r_res_r <= r_l ^ bus.data_out_b;
          r_done  <= 1'b1;
          r_state <= S_DONE;
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Block halves carry no reset; they are always loaded on accept before use.
  always_ff @(posedge clk) begin
    case (r_state)
      S_IDLE: if (w_accept) begin
        r_l <= w_load_l;
        r_r <= w_load_r;
      end
      S_RX: r_l <= w_lx;
      S_F1: r_f <= bus.data_out_a + bus.data_out_b;
      S_F2: begin
        r_l <= r_r ^ w_fo;
        r_r <= r_l;
      end
      default: ;
    endcase
  end

  assign bus.ready    = (r_state == S_IDLE);
  assign bus.done     = r_done;
  assign bus.result_l = r_res_l;
  assign bus.result_r = r_res_r;
  assign bus.addr_a   = w_addr_a;
  assign bus.addr_b   = w_addr_b;
  assign bus.cs_a_l   = w_cs_a_l;
  assign bus.cs_b_l   = w_cs_b_l;
  assign bus.we_a_l   = 1'b1;
  assign bus.we_b_l   = 1'b1;
  assign bus.oe_a_l   = 1'b0;
  assign bus.oe_b_l   = 1'b0;

endmodule

// File: tb/tb_blowfish_feistel_core.sv
// Directed bench for blowfish_feistel_core: zero SRAM, real zero-key Blowfish schedule (built from pi),
// busy/abort behaviour, a ROUNDS=4 instance, and the chain option when FEISTEL_CHAIN_EN is defined.
`timescale 1ns/1ps
module tb_blowfish_feistel_core;

  localparam int NW = 1047;

  logic clk;
  logic reset_l;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   lat;
  int   rdy_bad;
  logic [31:0] mid_l;
  logic [63:0] expv;

  logic [31:0] mem [0:4095];
  int unsigned pt [NW];
  int unsigned pq [NW];
  int unsigned pa [NW];

  blowfish_feistel_core_if #(.ADDR_W(12)) bus16 ();
  blowfish_feistel_core_if #(.ADDR_W(12)) bus4 ();

  blowfish_feistel_core #(.ROUNDS(16), .ADDR_W(12), .S_BASE(0), .P_BASE(1024)) u_dut16 (
    .clk(clk), .reset_l(reset_l), .bus(bus16.slave));
  blowfish_feistel_core #(.ROUNDS(4), .ADDR_W(12), .S_BASE(0), .P_BASE(1024)) u_dut4 (
    .clk(clk), .reset_l(reset_l), .bus(bus4.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (!bus16.cs_a_l) bus16.data_out_a <= mem[bus16.addr_a];
    if (!bus16.cs_b_l) bus16.data_out_b <= mem[bus16.addr_b];
    if (!bus4.cs_a_l)  bus4.data_out_a  <= mem[bus4.addr_a];
    if (!bus4.cs_b_l)  bus4.data_out_b  <= mem[bus4.addr_b];
  end

  initial begin
    #400000;
    $display("FAIL watchdog: time limit reached, compared=%0d", n_cmp);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Textbook Blowfish on the SRAM image (S at 0, P at 1024).
  function automatic logic [31:0] f_model(input logic [31:0] x);
    return ((mem[int'(x[31:24])] + mem[256 + int'(x[23:16])]) ^ mem[512 + int'(x[15:8])])
           + mem[768 + int'(x[7:0])];
  endfunction

  function automatic logic [63:0] bf_model(input int rounds, input bit dec,
                                           input logic [31:0] l, input logic [31:0] r);
    logic [31:0] xl, xr, t;
    xl = l;
    xr = r;
    for (int i = 0; i < rounds; i++) begin
      xl = xl ^ mem[1024 + (dec ? rounds + 1 - i : i)];
      xr = xr ^ f_model(xl);
      t = xl; xl = xr; xr = t;
    end
    t = xl; xl = xr; xr = t;
    xr = xr ^ mem[1024 + (dec ? 1 : rounds)];
    xl = xl ^ mem[1024 + (dec ? 0 : rounds + 1)];
    return {xl, xr};
  endfunction

  // Multiword fixed-point pi = 16*atan(1/5) - 4*atan(1/239); word 0 is the integer part.
  task automatic div_into(input bit to_q, input int unsigned d, input int from);
    longint unsigned rem, cur;
    rem = 0;
    for (int i = from; i < NW; i++) begin
      cur = (rem << 32) | {32'h0, pt[i]};
      if (to_q) pq[i] = 32'(cur / {32'h0, d});
      else      pt[i] = 32'(cur / {32'h0, d});
      rem = cur % {32'h0, d};
    end
  endtask

  task automatic acc_pq(input bit neg, input int from);
    longint unsigned s, cy;
    cy = 0;
    for (int i = NW - 1; i >= 0; i--) begin
      if (i < from && cy == 0) break;
      s = (i >= from) ? {32'h0, pq[i]} : 64'h0;
      if (neg) s = {32'h0, pa[i]} - s - cy;
      else     s = {32'h0, pa[i]} + s + cy;
      pa[i] = s[31:0];
      cy = neg ? {63'h0, s[63]} : (s >> 32);
    end
  endtask

  task automatic atan_series(input int unsigned c, input int unsigned x, input bit neg);
    int lead;
    int unsigned k;
    for (int i = 0; i < NW; i++) pt[i] = 0;
    pt[0] = c;
    div_into(1'b0, x, 0);
    lead = 0;
    k = 0;
    forever begin
      while (lead < NW && pt[lead] == 0) lead++;
      if (lead >= NW) break;
      div_into(1'b1, 2 * k + 1, lead);
      acc_pq(neg ^ k[0], lead);
      div_into(1'b0, x * x, lead);
      k++;
    end
  endtask

  task automatic build_schedule();
    logic [63:0] lr;
    for (int i = 0; i < NW; i++) pa[i] = 0;
    atan_series(16, 5, 1'b0);
    atan_series(4, 239, 1'b1);
    for (int k = 0; k < 18; k++)   mem[1024 + k] = pa[1 + k];
    for (int k = 0; k < 1024; k++) mem[k] = pa[19 + k];
    lr = 64'h0;
    for (int k = 0; k < 18; k += 2) begin
      lr = bf_model(16, 1'b0, lr[63:32], lr[31:0]);
      mem[1024 + k] = lr[63:32];
      mem[1025 + k] = lr[31:0];
    end
    for (int k = 0; k < 1024; k += 2) begin
      lr = bf_model(16, 1'b0, lr[63:32], lr[31:0]);
      mem[k]     = lr[63:32];
      mem[k + 1] = lr[31:0];
    end
  endtask

  // Cycle 0 = accept cycle; stops at the done cycle, or asserts reset at abort_at.
  task automatic run16(input logic dec, input logic [31:0] l, input logic [31:0] r,
                       input bit pulse, input int abort_at);
    @(negedge clk);
    bus16.start   = 1'b1;
    bus16.decrypt = dec;
    bus16.l_in    = l;
    bus16.r_in    = r;
    lat = -1;
    rdy_bad = 0;
    for (int c = 1; c <= 300; c++) begin
      @(negedge clk);
      if (c == 1 || c == 6 || c == 50) bus16.start = 1'b0;
      if (pulse && (c == 5 || c == 49)) begin
        bus16.start = 1'b1;
        bus16.l_in  = 32'hFFFF_FFFF;
      end
      if (c == 10) mid_l = bus16.result_l;
      if (c == abort_at) begin
        reset_l = 1'b0;
        #1;
        return;
      end
      if (bus16.ready !== 1'b0) rdy_bad++;
      if (bus16.done === 1'b1) begin
        lat = c;
        break;
      end
    end
  endtask

  task automatic run4(input logic dec, input logic [31:0] l, input logic [31:0] r);
    @(negedge clk);
    bus4.start   = 1'b1;
    bus4.decrypt = dec;
    bus4.l_in    = l;
    bus4.r_in    = r;
    lat = -1;
    for (int c = 1; c <= 100; c++) begin
      @(negedge clk);
      if (c == 1) bus4.start = 1'b0;
      if (bus4.done === 1'b1) begin
        lat = c;
        break;
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) mem[i] = 32'h0;
    bus16.start = 1'b0; bus16.decrypt = 1'b0; bus16.l_in = '0; bus16.r_in = '0;
    bus4.start  = 1'b0; bus4.decrypt  = 1'b0; bus4.l_in  = '0; bus4.r_in  = '0;
`ifdef FEISTEL_CHAIN_EN
    bus16.chain = 1'b0;
    bus4.chain  = 1'b0;
`endif
    reset_l = 1'b1;
    #2 reset_l = 1'b0;
    repeat (3) @(negedge clk);

    chk("rst_ready",    bus16.ready, 1);
    chk("rst_done",     bus16.done, 0);
    chk("rst_result",   {bus16.result_l, bus16.result_r}, 64'h0);
    chk("rst_cs",       {bus16.cs_a_l, bus16.cs_b_l}, 2'b11);
    chk("rst_addr",     {bus16.addr_a, bus16.addr_b}, 24'h0);
    chk("rst_we_oe",    {bus16.we_a_l, bus16.we_b_l, bus16.oe_a_l, bus16.oe_b_l}, 4'b1100);
    chk("rst4_state",   {bus4.ready, bus4.done, bus4.cs_a_l, bus4.cs_b_l}, 4'b1011);
    chk("rst4_we_oe",   {bus4.we_a_l, bus4.we_b_l, bus4.oe_a_l, bus4.oe_b_l}, 4'b1100);
    chk("rst4_result",  {bus4.result_l, bus4.result_r, bus4.addr_a, bus4.addr_b}, 88'h0);
    reset_l = 1'b1;

    // Zero SRAM: F is zero, so 16 swaps plus the final swap give the halves exchanged.
    run16(1'b0, 32'h0123_4567, 32'h89AB_CDEF, 1'b0, 0);
    chk("zero_lat",     lat, 50);
    chk("zero_busy",    rdy_bad, 0);
    chk("zero_result",  {bus16.result_l, bus16.result_r}, 64'h89AB_CDEF_0123_4567);
    @(negedge clk);
    chk("done_width",   bus16.done, 0);
    chk("ready_after",  bus16.ready, 1);
    chk("idle_cs",      {bus16.cs_a_l, bus16.cs_b_l}, 2'b11);

    build_schedule();
    run16(1'b0, 32'h0, 32'h0, 1'b0, 0);
    chk("enc0_lat",     lat, 50);
    chk("enc0_result",  {bus16.result_l, bus16.result_r}, 64'h4EF9_9745_6198_DD78);

    // Issued in the cycle right after done: exercises the back-to-back accept.
    run16(1'b1, 32'h4EF9_9745, 32'h6198_DD78, 1'b0, 0);
    chk("dec_lat",      lat, 50);
    chk("dec_hold_mid", mid_l, 32'h4EF9_9745);
    chk("dec_result",   {bus16.result_l, bus16.result_r}, 64'h0);

    run16(1'b0, 32'h0, 32'h0, 1'b1, 0);
    chk("busy_lat",     lat, 50);
    chk("busy_ready",   rdy_bad, 0);
    chk("busy_hold",    mid_l, 32'h0);
    chk("busy_result",  {bus16.result_l, bus16.result_r}, 64'h4EF9_9745_6198_DD78);
    repeat (5) @(negedge clk);
    chk("idle_hold",    {bus16.result_l, bus16.result_r}, 64'h4EF9_9745_6198_DD78);
    chk("idle_done",    bus16.done, 0);

    run16(1'b0, 32'h0, 32'h0, 1'b0, 20);
    chk("abort_result", {bus16.result_l, bus16.result_r}, 64'h0);
    chk("abort_ctl",    {bus16.done, bus16.ready, bus16.cs_a_l, bus16.cs_b_l}, 4'b0111);
    chk("abort_addr",   {bus16.addr_a, bus16.addr_b}, 24'h0);
    @(negedge clk);
    chk("abort_noread", {bus16.cs_a_l, bus16.cs_b_l, bus16.done}, 3'b110);
    reset_l = 1'b1;
    run16(1'b0, 32'h0, 32'h0, 1'b0, 0);
    chk("rerun_lat",    lat, 50);
    chk("rerun_result", {bus16.result_l, bus16.result_r}, 64'h4EF9_9745_6198_DD78);

    expv = bf_model(4, 1'b0, 32'h0123_4567, 32'h89AB_CDEF);
    run4(1'b0, 32'h0123_4567, 32'h89AB_CDEF);
    chk("r4_enc_lat",   lat, 14);
    chk("r4_enc",       {bus4.result_l, bus4.result_r}, expv);
    run4(1'b1, expv[63:32], expv[31:0]);
    chk("r4_dec_lat",   lat, 14);
    chk("r4_dec",       {bus4.result_l, bus4.result_r}, 64'h0123_4567_89AB_CDEF);

`ifdef FEISTEL_CHAIN_EN
    run16(1'b0, 32'h0, 32'h0, 1'b0, 0);
    chk("chain_op1",    {bus16.result_l, bus16.result_r}, 64'h4EF9_9745_6198_DD78);
    expv = bf_model(16, 1'b0, 32'h4EF9_9745, 32'h6198_DD78);
    bus16.chain = 1'b1;
    run16(1'b0, 32'hDEAD_BEEF, 32'hCAFE_F00D, 1'b0, 0);
    bus16.chain = 1'b0;
    chk("chain_lat",    lat, 50);
    chk("chain_op2",    {bus16.result_l, bus16.result_r}, expv);
`endif

    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
